// File: rtl/sliding_avg_pkg.sv
// Shared constants, types and helpers for the sliding-window averager.
// Purpose : width/rounding helper functions, window-state enum and a
//           fill-count type wide enough for the largest supported window.
// Ports   : none (package).
package sliding_avg_pkg;

   localparam int MAX_LOG2_SIZE = 8;

   // Wide enough to hold a count of 0..2**MAX_LOG2_SIZE.
   typedef logic [MAX_LOG2_SIZE:0] fill_cnt_t;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_FULL    = 2'd2
   } win_state_e;

   // A window of 2**log2_size samples, each fitting in width bits, sums into
   // width+log2_size bits without overflow.
   function automatic int sum_w(input int width, input int log2_size);
      return width + log2_size;
   endfunction

   // Offset added before the shift; half an LSB of the result gives round-half-up.
   function automatic int round_ofs(input int log2_size, input int round);
      return (round != 0) ? (1 << (log2_size - 1)) : 0;
   endfunction

   // Saturating increment of the window fill count.
   function automatic fill_cnt_t fill_inc(input fill_cnt_t f, input fill_cnt_t size);
      return (f >= size) ? size : f + fill_cnt_t'(1);
   endfunction

endpackage

// File: rtl/sliding_avg_ring.sv
// Ring buffer holding the last 2**LOG2_SIZE samples.
// Purpose : stores accepted samples at wr_ptr and exposes the slot under
//           wr_ptr (the sample about to be evicted) as "oldest".
// Ports   : clk, reset (async, active low), clear (restart pointer at 0),
//           wr_en / wr_data (store a sample), oldest (slot at current pointer).
module sliding_avg_ring
   import sliding_avg_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LOG2_SIZE = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] oldest
);

   localparam int SIZE = 1 << LOG2_SIZE;

   logic [LOG2_SIZE-1:0] wr_ptr_q, wr_ptr_d, wr_idx;
   logic [WIDTH-1:0]     mem_q [SIZE];

   // A write in the same cycle as clear lands in slot 0 of the fresh window.
   always_comb begin
      wr_idx   = clear ? '0 : wr_ptr_q;
      wr_ptr_d = wr_en ? wr_idx + LOG2_SIZE'(1) : wr_idx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wr_ptr_q <= '0;
      else        wr_ptr_q <= wr_ptr_d;
   end

   // Storage is deliberately not reset: the top ignores slots until the
   // window has been completely written once.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_data;
   end

   assign oldest = mem_q[wr_ptr_q];

endmodule

// File: rtl/sliding_average_hs.sv
// Streaming signed moving average over a 2**LOG2_SIZE sample window.
// Purpose : O(1) running sum (add newest, subtract oldest), divide by the
//           window size via arithmetic shift, optional round-half-up.
// Ports   : clk, reset (async, active low), clear (sync window restart),
//           in_valid/in_ready/in_data (sample in), out_valid/out_ready/
//           out_data (average out), out_full (result covers a whole window),
//           fill (valid samples in window, saturates at SIZE).
module sliding_average_hs
   import sliding_avg_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LOG2_SIZE = 2,
   parameter int ROUND     = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_data,
   output logic                    out_full,
   output logic [LOG2_SIZE:0]      fill
);

   localparam int SIZE  = 1 << LOG2_SIZE;
   localparam int SUM_W = sum_w(WIDTH, LOG2_SIZE);
   localparam logic [LOG2_SIZE:0]       SIZE_F = (LOG2_SIZE + 1)'(SIZE);
   localparam logic signed [SUM_W-1:0]  OFS    = SUM_W'(round_ofs(LOG2_SIZE, ROUND));

   logic signed [SUM_W-1:0] sum_q, sum_d;
   logic [LOG2_SIZE:0]      fill_q, fill_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [WIDTH-1:0] out_data_q, out_data_d;
   logic                    out_full_q, out_full_d;
   win_state_e              state_q, state_d;

   logic                    accept;
   logic [WIDTH-1:0]        oldest;
   logic signed [SUM_W-1:0] sum_base, oldest_ext, sum_n, sum_rnd, sum_shift;
   logic [LOG2_SIZE:0]      fill_base;
   fill_cnt_t               fill_wide;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   sliding_avg_ring #(
      .WIDTH     (WIDTH),
      .LOG2_SIZE (LOG2_SIZE)
   ) u_ring (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .wr_en   (accept),
      .wr_data (in_data),
      .oldest  (oldest)
   );

   always_comb begin
      // clear takes effect first so a same-cycle sample opens a fresh window.
      sum_base  = clear ? '0 : sum_q;
      fill_base = clear ? '0 : fill_q;
      // Until the window is full the slot under the pointer was never written
      // in this window and must count as zero.
      oldest_ext = (!clear && state_q == ST_FULL) ? SUM_W'(signed'(oldest)) : '0;
      sum_n      = sum_base + SUM_W'(in_data) - oldest_ext;
      sum_rnd    = sum_n + OFS;
      sum_shift  = sum_rnd >>> LOG2_SIZE;
      fill_wide  = fill_inc(fill_cnt_t'(fill_base), fill_cnt_t'(SIZE));

      sum_d       = sum_q;
      fill_d      = fill_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_full_d  = out_full_q;

      if (clear) begin
         sum_d       = '0;
         fill_d      = '0;
         out_valid_d = 1'b0;
         out_full_d  = 1'b0;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         sum_d       = sum_n;
         fill_d      = fill_wide[LOG2_SIZE:0];
         out_data_d  = sum_shift[WIDTH-1:0];
         out_full_d  = (fill_d == SIZE_F);
         out_valid_d = 1'b1;
      end

      if (fill_d == '0)         state_d = ST_EMPTY;
      else if (fill_d == SIZE_F) state_d = ST_FULL;
      else                      state_d = ST_FILLING;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_q       <= '0;
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_full_q  <= 1'b0;
         state_q     <= ST_EMPTY;
      end else begin
         sum_q       <= sum_d;
         fill_q      <= fill_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_full_q  <= out_full_d;
         state_q     <= state_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_full  = out_full_q;
   assign fill      = fill_q;

endmodule

// File: tb/tb_sliding_average_hs.sv
// Directed self-checking bench for sliding_average_hs (floor and rounding builds).
module tb_sliding_average_hs;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Floor build
   logic              reset, clear, in_valid, in_ready, out_valid, out_ready, out_full;
   logic signed [7:0] in_data, out_data;
   logic [2:0]        fill;

   // Round-half-up build
   logic              r_reset, r_clear, r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_out_full;
   logic signed [7:0] r_in_data, r_out_data;
   logic [2:0]        r_fill;

   int errors = 0;
   int checks = 0;

   sliding_average_hs #(.WIDTH(8), .LOG2_SIZE(2), .ROUND(0)) u_dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_full(out_full), .fill(fill)
   );

   sliding_average_hs #(.WIDTH(8), .LOG2_SIZE(2), .ROUND(1)) u_dut_r (
      .clk(clk), .reset(r_reset), .clear(r_clear),
      .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
      .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
      .out_full(r_out_full), .fill(r_fill)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One-cycle accept on the floor build; outputs sampled 1 time unit after the edge.
   task automatic push(input int d);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(d);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic push_r(input int d);
      @(negedge clk);
      r_in_valid = 1'b1;
      r_in_data  = 8'(d);
      @(posedge clk);
      #1;
      r_in_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   // Reference model for the backpressure stream: last 4 samples, floor average.
   int hist[$];
   function automatic int model_avg(input int v);
      int s;
      hist.push_back(v);
      if (hist.size() > 4) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += hist[i];
      return s >>> 2;
   endfunction

   initial begin
      int exp_out[5]  = '{1, 3, 6, 10, 14};
      int exp_full[5] = '{0, 0, 0, 1, 1};
      int exp_fill[5] = '{1, 2, 3, 4, 4};
      int feed[5]     = '{4, 8, 12, 16, 20};
      int neg_out[4]  = '{-1, -2, -3, -4};
      int hi_out[4]   = '{31, 63, 95, 127};
      int lo_out[4]   = '{63, -1, -65, -128};
      int rnd_out[4]  = '{0, -1, -1, -2};
      int vals[8]     = '{10, -20, 30, 40, -50, 60, 70, -80};
      int expq[$];
      int idx, held;
      logic pop, acc;
      logic signed [7:0] popped;

      reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      r_reset = 1'b0; r_clear = 1'b0; r_in_valid = 1'b0; r_in_data = '0; r_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_full", int'(out_full), 0);
      chk("rst_fill", int'(fill), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      reset = 1'b1; r_reset = 1'b1;

      // Ramp fill and first full-window slide
      for (int i = 0; i < 5; i++) begin
         push(feed[i]);
         chk($sformatf("ramp_valid%0d", i), int'(out_valid), 1);
         chk($sformatf("ramp_out%0d", i), int'(out_data), exp_out[i]);
         chk($sformatf("ramp_full%0d", i), int'(out_full), exp_full[i]);
         chk($sformatf("ramp_fill%0d", i), int'(fill), exp_fill[i]);
      end

      // Clear then negative samples
      pulse_clear();
      chk("clr_fill", int'(fill), 0);
      chk("clr_valid", int'(out_valid), 0);
      for (int i = 0; i < 4; i++) begin
         push(-4);
         chk($sformatf("neg_out%0d", i), int'(out_data), neg_out[i]);
      end

      // Extremes: max then min through a full window, no wrap
      pulse_clear();
      for (int i = 0; i < 4; i++) begin
         push(127);
         chk($sformatf("max_out%0d", i), int'(out_data), hi_out[i]);
      end
      for (int i = 0; i < 4; i++) begin
         push(-128);
         chk($sformatf("min_out%0d", i), int'(out_data), lo_out[i]);
      end
      chk("min_fill", int'(fill), 4);

      // clear together with an accepted sample while full
      @(negedge clk);
      clear = 1'b1; in_valid = 1'b1; in_data = 8'sd100;
      @(posedge clk);
      #1;
      clear = 1'b0; in_valid = 1'b0;
      chk("clracc_out", int'(out_data), 25);
      chk("clracc_fill", int'(fill), 1);
      chk("clracc_full", int'(out_full), 0);
      chk("clracc_valid", int'(out_valid), 1);

      // Backpressure: hold output, then drain a stream against the model
      pulse_clear();
      hist.delete();
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'(vals[0]);
      @(posedge clk);
      #1;
      expq.push_back(model_avg(vals[0]));
      chk("bp_out0", int'(out_data), 2);
      @(negedge clk);
      in_data = 8'(vals[1]);
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      held = int'(out_data);
      @(posedge clk);
      #1;
      chk("bp_hold_data", int'(out_data), 2);
      chk("bp_hold_fill", int'(fill), 1);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_held_stable", int'(out_data), held);
      idx = 1;
      for (int cyc = 0; cyc < 60 && (idx < 8 || expq.size() != 0); cyc++) begin
         @(negedge clk);
         out_ready = (cyc % 3) != 2;
         in_valid  = idx < 8;
         in_data   = 8'(vals[idx < 8 ? idx : 0]);
         #1;
         pop    = out_valid && out_ready;
         acc    = in_valid && in_ready;
         popped = out_data;
         @(posedge clk);
         if (pop) begin
            if (expq.size() == 0) chk("bp_extra_out", int'(popped), 9999);
            else                  chk("bp_stream", int'(popped), expq.pop_front());
         end
         if (acc) begin
            expq.push_back(model_avg(vals[idx]));
            idx++;
         end
      end
      #1;
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_all_accepted", idx, 8);
      chk("bp_all_drained", expq.size(), 0);
      @(posedge clk);
      #1;
      chk("bp_idle_valid", int'(out_valid), 0);

      // Reset mid-stream with fill=3 and a pending output
      pulse_clear();
      push(4); push(8); push(12);
      chk("mid_fill_pre", int'(fill), 3);
      chk("mid_valid_pre", int'(out_valid), 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_data", int'(out_data), 0);
      chk("mid_rst_fill", int'(fill), 0);
      @(negedge clk);
      reset = 1'b1;
      push(8);
      chk("post_rst_out", int'(out_data), 2);
      chk("post_rst_fill", int'(fill), 1);

      // Round-half-up build
      for (int i = 0; i < 4; i++) begin
         push_r(-2);
         chk($sformatf("rnd_out%0d", i), int'(r_out_data), rnd_out[i]);
      end
      chk("rnd_full", int'(r_out_full), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
